// File: rtl/adder_arb_pkg.sv
// Shared types for the adder arbiter slice.
package adder_arb_pkg;

    localparam int DATA_W   = 32;
    localparam int ID_MAX_W = 4;

    // id is wide enough for 16 requesters; the top uses only its low IDW bits
    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [DATA_W-1:0]   res;
        logic                ovfl;
    } rsp_entry_t;

endpackage

// File: rtl/adder_rsp_fifo.sv
// Synchronous response FIFO holding adder results tagged with requester id.
module adder_rsp_fifo
    import adder_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  rsp_entry_t                 din,
    input  logic                       pop,
    output rsp_entry_t                 dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    rsp_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one registered adder among NREQ requesters,
// with credit-protected in-order response return.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DATA_W-1:0]   req_a,
    input  logic [NREQ*DATA_W-1:0]   req_b,
    output logic [DATA_W-1:0]        add_ina,
    output logic [DATA_W-1:0]        add_inb,
    input  logic [DATA_W-1:0]        add_res,
    input  logic                     add_ovfl,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]        rsp_res,
    output logic                     rsp_ovfl,
    output logic [31:0]              ops_done
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(RSP_DEPTH + 1);

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  rr_nxt;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  id_q;
    logic [NREQ-1:0] grant;
    logic            gnt_any;
    logic            inflight;
    logic            can_issue;
    logic            pop;
    logic [CW-1:0]   fifo_count;
    rsp_entry_t      push_e;
    rsp_entry_t      head;

    // A pop frees a slot this cycle, so it also lends a credit this cycle
    assign pop       = |(rsp_valid & rsp_ready);
    assign can_issue = ((int'(fifo_count) + int'(inflight)) < RSP_DEPTH) | pop;

    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        if (can_issue) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!gnt_any && req_valid[idx]) begin
                    gnt_any     = 1'b1;
                    gnt_id      = IDW'(idx);
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;
    assign add_ina   = gnt_any ? req_a[DATA_W*gnt_id +: DATA_W] : '0;
    assign add_inb   = gnt_any ? req_b[DATA_W*gnt_id +: DATA_W] : '0;
    assign rr_nxt    = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            inflight <= 1'b0;
            id_q     <= '0;
            ops_done <= '0;
        end else begin
            inflight <= gnt_any;
            if (gnt_any) begin
                rr_ptr <= rr_nxt;
                id_q   <= gnt_id;
            end
            if (pop) ops_done <= ops_done + 32'd1;
        end
    end

    assign push_e = '{id: ID_MAX_W'(id_q), res: add_res, ovfl: add_ovfl};

    adder_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (push_e),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    always_comb begin
        rsp_valid = '0;
        if (fifo_count != '0) rsp_valid[head.id[IDW-1:0]] = 1'b1;
    end

    assign rsp_res  = head.res;
    assign rsp_ovfl = head.ovfl;

endmodule
